// File: rtl/mux_n_buf.sv
// One-based N:1 word selector feeding a 2-entry output FIFO with ready/valid handshakes.
// Illegal selects are dropped, flagged with a one-cycle pulse and tallied in a saturating counter.
module mux_n_buf #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        choice,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    bad_sel,
    output logic [7:0]              bad_cnt
);

    if (WIDTH < 1) begin : g_chk_width
        $error("mux_n_buf: WIDTH must be at least 1");
    end
    if (NUM_IN < 2 || NUM_IN > 255) begin : g_chk_num_in
        $error("mux_n_buf: NUM_IN must be in 2..255");
    end
    if ((2 ** SEL_W) <= NUM_IN) begin : g_chk_sel_w
        $error("mux_n_buf: 2**SEL_W must exceed NUM_IN");
    end

    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] sel_word;
    logic             legal;
    logic             accept;
    logic             push;
    logic             pop;

    // Choice c selects input c-1; any value without a match (0 or > NUM_IN) is illegal.
    always_comb begin
        sel_word = '0;
        legal    = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (choice == SEL_W'(k + 1)) begin
                sel_word = in_bus[k*WIDTH +: WIDTH];
                legal    = 1'b1;
            end
        end
    end

    assign in_ready  = (count != 2'd2) && ena && !rst;
    assign out_valid = (count != 2'd0);
    assign out       = head;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    // head is never cleared on pop, so it keeps the last word seen when the FIFO runs empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            head    <= '0;
            tail    <= '0;
            bad_sel <= 1'b0;
            bad_cnt <= 8'd0;
        end else begin
            bad_sel <= accept && !legal;
            if (accept && !legal && bad_cnt != 8'hFF) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= sel_word;
                    end else begin
                        tail <= sel_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                // Push needs count < 2 and pop needs count > 0, so this is only reachable at count 1.
                2'b11: begin
                    head <= sel_word;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_n_buf.sv
// Randomized and directed bench for mux_n_buf against a queue-based reference model.
module tb_mux_n_buf;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 3;

    logic                    clk;
    logic                    rst;
    logic                    ena;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        choice;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    bad_sel;
    logic [7:0]              bad_cnt;

    mux_n_buf #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_bus(in_bus), .choice(choice),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .bad_sel(bad_sel), .bad_cnt(bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_popped;
    int               m_bad_cnt;
    logic             m_bad_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_popped = '0;
        m_bad_cnt   = 0;
        m_bad_sel   = 1'b0;
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] exp_out;
        exp_out = (q.size() != 0) ? q[0] : last_popped;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out",       out,            exp_out);
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2 && ena && !rst));
        chk("bad_sel",   32'(bad_sel),   32'(m_bad_sel));
        chk("bad_cnt",   32'(bad_cnt),   32'(m_bad_cnt));
    endtask

    // Inputs are already set (just after a falling edge); advance one rising edge and check.
    task automatic cycle();
        logic             acc;
        logic             pp;
        logic             lg;
        logic [WIDTH-1:0] word;
        int               c;
        c    = int'(choice);
        lg   = (c >= 1 && c <= NUM_IN);
        word = lg ? in_bus[(c-1)*WIDTH +: WIDTH] : '0;
        acc  = in_valid && ena && !rst && (q.size() < 2);
        pp   = !rst && (q.size() != 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (pp) last_popped = q.pop_front();
            if (acc && lg) q.push_back(word);
            m_bad_sel = acc && !lg;
            if (acc && !lg && m_bad_cnt < 255) m_bad_cnt++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input logic v, input int c, input logic e, input logic r);
        in_valid  = v;
        choice    = SEL_W'(c);
        ena       = e;
        out_ready = r;
        for (int k = 0; k < NUM_IN; k++) in_bus[k*WIDTH +: WIDTH] = $urandom;
    endtask

    logic [WIDTH-1:0] sel_words [NUM_IN];

    initial begin
        model_reset();
        rst = 1'b1;
        set_in(1'b1, 1, 1'b1, 1'b1);
        @(negedge clk);

        // Reset held with in_valid high: nothing accepted.
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_out", out, '0);
        rst = 1'b0;
        set_in(1'b0, 1, 1'b1, 1'b1);
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        cycle();

        // Back-to-back selects with fixed data.
        sel_words[0] = 32'hAAAA; sel_words[1] = 32'hBBBB;
        sel_words[2] = 32'hCCCC; sel_words[3] = 32'hDDDD;
        for (int c = 1; c <= NUM_IN; c++) begin
            in_valid = 1'b1; choice = SEL_W'(c); out_ready = 1'b1; ena = 1'b1;
            for (int k = 0; k < NUM_IN; k++) in_bus[k*WIDTH +: WIDTH] = sel_words[k];
            cycle();
            chk("sel_out", out, sel_words[c-1]);
            chk("sel_valid", 32'(out_valid), 32'd1);
        end
        set_in(1'b0, 1, 1'b1, 1'b1);
        cycle();

        // Backpressure: three offers, two accepted.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, i + 1, 1'b1, 1'b0);
            if (i == 2) chk("bp_ready_3rd", 32'(in_ready), 32'd0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 3, 1'b1, 1'b1);
            cycle();
        end
        set_in(1'b0, 1, 1'b1, 1'b1);
        cycle(); cycle();

        // Illegal selects 0, 5, 7.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, (i == 0) ? 0 : ((i == 1) ? 5 : 7), 1'b1, 1'b1);
            cycle();
            chk("ill_pulse", 32'(bad_sel), 32'd1);
        end
        set_in(1'b0, 1, 1'b1, 1'b1);
        cycle();
        chk("ill_cnt3", 32'(bad_cnt), 32'd3);
        chk("ill_nopush", 32'(out_valid), 32'd0);
        chk("ill_pulse_end", 32'(bad_sel), 32'd0);
        for (int i = 0; i < 260; i++) begin
            set_in(1'b1, (i % 2 == 0) ? 0 : int'($urandom_range(5, 7)), 1'b1, 1'b1);
            cycle();
        end
        chk("ill_sat", 32'(bad_cnt), 32'd255);

        // ena low drains a full FIFO without accepting.
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 2, 1'b1, 1'b0);
            cycle();
        end
        chk("full_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4, 1'b0, 1'b1);
            cycle();
        end
        chk("ena_drained", 32'(out_valid), 32'd0);

        // Async reset at count 2 clears immediately.
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1, 1'b1, 1'b0);
            cycle();
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_out", out, '0);
        chk("arst_cnt", 32'(bad_cnt), 32'd0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        set_in(1'b1, 2, 1'b1, 1'b1);
        cycle();
        chk("first_accept", 32'(out_valid), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4)),
                   1'($urandom_range(0, 7) != 0),
                   1'($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_buf.md
MUX_N_BUF -- requirements
Module: mux_n_buf

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; legal range is 1 or more.
REQ-002 Parameter NUM_IN, default 4, number of data inputs; legal range is 2..255.
REQ-003 Parameter SEL_W, default 3, width of choice; 2^SEL_W SHALL exceed NUM_IN (elaboration-time check).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ena  input  1  block enable; when 0, no input is accepted.
REQ-007 in_bus  input  NUM_IN*WIDTH  flattened data inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 choice  input  SEL_W  one-based select; value c in 1..NUM_IN picks input c-1.
REQ-009 in_valid  input  1  producer presents a choice and data this cycle.
REQ-010 in_ready  output  1  block can accept this cycle.
REQ-011 out  output  WIDTH  selected word at the buffer head.
REQ-012 out_valid  output  1  out holds an unconsumed word.
REQ-013 out_ready  input  1  consumer takes out this cycle.
REQ-014 bad_sel  output  1  one-cycle pulse: an accepted transfer carried an illegal choice.
REQ-015 bad_cnt  output  8  count of illegal-choice transfers, saturating.

Function
REQ-016 Storage SHALL be a 2-entry FIFO of WIDTH-bit words with a 2-bit occupancy count (0..2).
REQ-017 in_ready SHALL equal (count < 2) AND ena AND NOT rst; it is combinational from registered state only, with no path from in_valid or out_ready.
REQ-018 An accept happens when in_valid AND in_ready are high at a rising edge.
REQ-019 An accept with a legal choice (1..NUM_IN) SHALL push in_bus[(choice-1)*WIDTH +: WIDTH], sampled at that edge.
REQ-020 An accept with an illegal choice (0 or greater than NUM_IN) SHALL push nothing, set bad_sel high for the next cycle only, and increment bad_cnt by 1, saturating at 255.
REQ-021 out_valid SHALL equal (count != 0); a pop happens when out_valid AND out_ready are high at a rising edge.
REQ-022 Latency: a word pushed at edge N SHALL appear on out with out_valid high after edge N when the FIFO was empty.
REQ-023 A simultaneous push and pop at count 1 SHALL leave count at 1, with out becoming the new word.
REQ-024 A simultaneous push and pop at count 0 SHALL NOT occur, because out_valid is 0 when count is 0.
REQ-025 At count 2, in_ready is 0, so no push can happen; a pop SHALL move the second entry to the head.
REQ-026 Words SHALL leave in strict acceptance order; none SHALL be dropped or duplicated.
REQ-027 When count is 0, out SHALL hold the most recently popped word (0 if nothing has been popped since reset).
REQ-028 ena = 0 SHALL block accepts only; the FIFO SHALL still drain through out_ready.
REQ-029 Sustained in_valid, out_ready and legal choices SHALL give 1 word per cycle after the first-word latency.

Reset
REQ-030 While rst is high, count = 0, out = 0, out_valid = 0, in_ready = 0, bad_sel = 0, bad_cnt = 0, and both FIFO entries = 0.
REQ-031 Asserting rst mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-032 The first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-033 Reset: rst held for 3 cycles with in_valid = 1 -> no accept, out = 0, out_valid = 0, bad_cnt = 0; after release, in_ready = 1 (ena = 1).
REQ-034 Select: NUM_IN = 4, in_bus = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, choice = 1, 2, 3, 4 back-to-back, out_ready = 1 -> out = AAAA, BBBB, CCCC, DDDD on consecutive cycles, 1 cycle after each accept.
REQ-035 Backpressure: out_ready = 0 with 3 legal offers -> 2 accepted, in_ready = 0 on the 3rd; release out_ready -> the two words come out in order, then the 3rd is accepted.
REQ-036 Illegal choice: choice = 0, then 5, then 7 accepted -> no push, bad_sel pulses 3 times, bad_cnt = 3; 260 illegal accepts -> bad_cnt = 255.
REQ-037 Enable and reset: ena = 0 with count = 2 and out_ready = 1 -> drains to 0 with no accept; rst pulsed at count = 2 -> out_valid = 0 immediately.
